cmp_capture: RTL and testbench
==============================

# cmp_capture

Comparator decision capture and accumulation stage, directly downstream of the comparator phase generator. It watches the evaluate phase `cmp_p1` and samples the latched comparator output once per evaluate phase, at a fixed settle delay after the phase rises. It counts the number of "1" decisions over a window of 2^WINDOW_LOG2 phases and hands the count to the digital back-end over a valid/ready handshake.

## Interface
- `WINDOW_LOG2`, 4: decisions per window = 2^WINDOW_LOG2; legal range 1..10.
- `SETTLE`, 2: clk cycles between detecting `cmp_p1` rising and entering SAMPLE; legal range 0..2.

- `clk` in 1: single clock, shared with the phase generator.
- `reset` in 1: synchronous, active-high.
- `cmp_p1` in 1: evaluate phase, synchronous to `clk`.
- `cmp_out` in 1: raw comparator latch output, asynchronous.
- `enable` in 1: capture enable.
- `ready` in 1: consumer accepts `count`.
- `count` out WINDOW_LOG2+1: number of 1-decisions in the last published window, 0..2^WINDOW_LOG2.
- `valid` out 1: `count` holds an unconsumed result.
- `overrun` out 1: sticky; a window completed while an unconsumed result was pending.
- `decision` out 1: most recent sampled decision.
- `busy` out 1: high in every state except IDLE.

## Operation
- Synchronizer: `cmp_out` passes through a 2-flop synchronizer (`sync2`). Only `sync2` is ever sampled.
- Edge detect: register `cmp_p1` into `p1_d`. `rise = cmp_p1 & ~p1_d`.
- State machine states: IDLE, WAIT_EDGE, SETTLE, SAMPLE.
  - IDLE: if `enable` is high, go to WAIT_EDGE.
  - WAIT_EDGE: on `rise`, go to SAMPLE when SETTLE==0. Otherwise go to SETTLE with `scnt`=0.
  - SETTLE: if `scnt`==SETTLE-1, go to SAMPLE; otherwise increment `scnt`. A `rise` seen in SETTLE is ignored.
  - SAMPLE: one cycle, then go to WAIT_EDGE.
  - Any state: `enable` low forces IDLE on the next edge. This has priority over all other transitions.
- SAMPLE update:
  - `decision <= sync2`.
  - `acc <= acc + sync2`.
  - `n <= n + 1`.
  - `acc` and `n` are WINDOW_LOG2+1 bits wide.
- Publish: when SAMPLE processes the 2^WINDOW_LOG2-th decision, the result is offered for publishing, `acc` and `n` clear to 0, and the next window starts at the next `rise`.
- Handshake:
  - A transfer occurs on any edge where `valid` and `ready` are both high.
  - After a transfer, `valid` falls unless a publish occurs on the same edge. In that case the new count loads and `valid` stays 1.
  - When `valid` is high and there is no transfer, `count` is stable.
- Overrun: if a publish occurs while `valid` is high with no transfer on that edge:
  - the new result is dropped;
  - `count` keeps the old value;
  - `overrun` is set to 1;
  - `overrun` clears only on `reset`.
- Enable low:
  - `acc` and `n` clear on the edge entering IDLE, so a partial window is discarded.
  - `valid`, `count`, and `overrun` are unaffected; a pending result can still be consumed.
- Reset values: state=IDLE, `acc`=0, `n`=0, `scnt`=0, `p1_d`=0, `sync2` chain=0, `count`=0, `valid`=0, `overrun`=0, `decision`=0, `busy`=0.

## Timing
- Edge E is the clk edge where `cmp_p1` is first sampled high while in WAIT_EDGE.
- State is SAMPLE during the cycle after edge E+SETTLE.
- The decision registers at edge E+SETTLE+1.
- `decision`, `count`, and `valid` are visible after edge E+SETTLE+1. There is no further output latency.
- `sync2` at the sampling edge reflects `cmp_out` as captured by the first sync flop 2 edges earlier.
- Sampling is not qualified by the `cmp_p1` level.
- With the phase generator (toggle every 4 clk, 8-clk period), `cmp_p1` is high at edges E..E+3, so SETTLE≤2 always samples inside evaluate.
- One window takes 2^WINDOW_LOG2 × 8 clk in steady state.
- Boundary cases:
  - `rise` in the same cycle `enable` falls: IDLE wins and no sample is taken.
  - `enable` rising during `cmp_p1` high: no sample until the next true `rise`.
  - `reset` mid-window: everything returns to reset values on that edge.
  - Full window of 1s: `count` = 2^WINDOW_LOG2. The accumulator never wraps.

## Test plan
- Constant 1, WINDOW_LOG2=4, SETTLE=2, phase generator model, `ready`=1: after 16 rises, `count`=16 and `valid` is high for 1 cycle. The next result arrives 128 clk later.
- Alternating 1/0 per phase, `ready`=1: `count`=8 every window. `decision` toggles each SAMPLE. `overrun`=0.
- `ready`=0 across two windows of constant 0, then constant 1: `count` stays 0, `valid` stays 1, and `overrun`=1 after the second window. Raising `ready` clears `valid` on the next edge.
- `ready` pulsed high exactly on the publish edge of window 2: `count` takes the new value, `valid` stays 1, and `overrun` stays 0.
- Constant 1, `enable` dropped after 5 samples and raised again: no publish for the partial window. The next publish after 16 more rises is `count`=16. `busy`=0 while disabled.
- `reset` asserted for 1 cycle after 10 samples with `valid` high: all outputs return to 0. The first subsequent window publishes 16 (constant 1).

Source files
------------

// File: rtl/cmp_capture.sv
// Purpose : samples the synchronized comparator decision once per evaluate phase
//           (SETTLE clks after cmp_p1 rises) and counts 1-decisions per window.
// Latency : decision/count/valid update on edge E+SETTLE+1 (E = edge seeing the rise).
// Backpressure: valid/ready; a window finishing while a result is still pending
//           is dropped and flags sticky overrun.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   cmp_p1          evaluate phase from the phase generator (clk-synchronous)
//   cmp_out         raw comparator latch output (asynchronous, synchronized here)
//   enable          capture enable; low discards the partial window
//   ready           consumer accepts count
//   count           number of 1-decisions in the last published window
//   valid           count holds an unconsumed result
//   overrun         sticky: a window result was dropped because one was pending
//   decision        most recent sampled decision
//   busy            state machine is not idle
module cmp_capture #(
    parameter int WINDOW_LOG2 = 4,
    parameter int SETTLE      = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmp_p1,
    input  logic                   cmp_out,
    input  logic                   enable,
    input  logic                   ready,
    output logic [WINDOW_LOG2:0]   count,
    output logic                   valid,
    output logic                   overrun,
    output logic                   decision,
    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_SETTLE    = 2'd2,
        ST_SAMPLE    = 2'd3
    } state_t;

    // n reaching 2^WINDOW_LOG2 marks the last decision of a window.
    localparam logic [WINDOW_LOG2:0] WIN_N     = {1'b1, {WINDOW_LOG2{1'b0}}};
    localparam logic [1:0]           SCNT_LAST = (SETTLE == 0) ? 2'd0 : 2'(SETTLE - 1);

    state_t                 state_q, state_d;
    logic [1:0]             scnt_q, scnt_d;
    logic [WINDOW_LOG2:0]   acc_q, acc_d;
    logic [WINDOW_LOG2:0]   n_q, n_d;
    logic [WINDOW_LOG2:0]   count_q, count_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   decision_q, decision_d;
    logic                   busy_q, busy_d;
    logic                   p1_q, p1_d;
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;

    logic                   rise;
    logic                   xfer;
    logic                   publish;
    logic [WINDOW_LOG2:0]   acc_inc;
    logic [WINDOW_LOG2:0]   n_inc;

    always_comb begin
        sync1_d    = cmp_out;
        sync2_d    = sync1_q;
        p1_d       = cmp_p1;
        rise       = cmp_p1 & ~p1_q;
        xfer       = valid_q & ready;
        acc_inc    = acc_q + {{WINDOW_LOG2{1'b0}}, sync2_q};
        n_inc      = n_q + {{WINDOW_LOG2{1'b0}}, 1'b1};

        state_d    = state_q;
        scnt_d     = scnt_q;
        acc_d      = acc_q;
        n_d        = n_q;
        count_d    = count_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        decision_d = decision_q;
        publish    = 1'b0;

        if (xfer) begin
            valid_d = 1'b0;
        end

        if (!enable) begin
            // Disable wins over every transition, including a rise or a
            // pending sample on this edge; the partial window is discarded.
            state_d = ST_IDLE;
            acc_d   = '0;
            n_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_EDGE;
                end
                ST_WAIT_EDGE: begin
                    if (rise) begin
                        if (SETTLE == 0) begin
                            state_d = ST_SAMPLE;
                        end else begin
                            state_d = ST_SETTLE;
                            scnt_d  = 2'd0;
                        end
                    end
                end
                ST_SETTLE: begin
                    // Rises here are ignored: one sample per evaluate phase.
                    if (scnt_q == SCNT_LAST) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        scnt_d = scnt_q + 2'd1;
                    end
                end
                ST_SAMPLE: begin
                    state_d    = ST_WAIT_EDGE;
                    decision_d = sync2_q;
                    if (n_inc == WIN_N) begin
                        publish = 1'b1;
                        acc_d   = '0;
                        n_d     = '0;
                    end else begin
                        acc_d = acc_inc;
                        n_d   = n_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A publish lands only if the output slot is free or being drained
        // on this same edge; otherwise the old count is kept.
        if (publish) begin
            if (!valid_q || xfer) begin
                count_d = acc_inc;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            scnt_q     <= 2'd0;
            acc_q      <= '0;
            n_q        <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            decision_q <= 1'b0;
            busy_q     <= 1'b0;
            p1_q       <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            acc_q      <= acc_d;
            n_q        <= n_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            decision_q <= decision_d;
            busy_q     <= busy_d;
            p1_q       <= p1_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
        end
    end

    assign count    = count_q;
    assign valid    = valid_q;
    assign overrun  = overrun_q;
    assign decision = decision_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_cmp_capture.sv
// Purpose : directed bench for cmp_capture (WINDOW_LOG2=4, SETTLE=2) driven by a
//           phase generator model (cmp_p1 toggles every 4 clk).
// Latency : outputs sampled on the falling edge, half a cycle after each update.
// Backpressure: ready is driven per scenario to exercise transfer and overrun.
module tb_cmp_capture;

    logic       clk;
    logic       reset;
    logic       cmp_p1;
    logic       cmp_out;
    logic       enable;
    logic       ready;
    logic [4:0] count;
    logic       valid;
    logic       overrun;
    logic       decision;
    logic       busy;

    cmp_capture #(
        .WINDOW_LOG2 (4),
        .SETTLE      (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmp_p1   (cmp_p1),
        .cmp_out  (cmp_out),
        .enable   (enable),
        .ready    (ready),
        .count    (count),
        .valid    (valid),
        .overrun  (overrun),
        .decision (decision),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Phase generator model state
    logic        gen_on = 1'b0;
    int          ph     = 0;
    int          ridx   = 0;      // rises generated since gen_on
    logic [15:0] mask_a = 16'h0;  // cmp_out per phase, first 16 phases
    logic [15:0] mask_b = 16'h0;  // cmp_out per phase afterwards

    typedef struct {
        logic [15:0] mask;
        int          exp_count;
        logic        exp_dec;
    } vec_t;

    vec_t vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // cmp_p1 held 4 edges high, 4 edges low; cmp_out set per phase at the rise.
    initial begin
        cmp_p1  = 1'b0;
        cmp_out = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!gen_on) begin
                ph      = 0;
                ridx    = 0;
                cmp_p1  = 1'b0;
                cmp_out = 1'b0;
            end else begin
                ph++;
                if (ph == 4) begin
                    ph     = 0;
                    cmp_p1 = ~cmp_p1;
                    if (cmp_p1) begin
                        logic [3:0] bi;
                        bi      = 4'(ridx);
                        cmp_out = (ridx < 16) ? mask_a[bi] : mask_b[bi];
                        ridx++;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, input int limit);
        int k;
        k = 0;
        while (valid !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: valid=%0b after %0d cycles expected 1", name, valid, limit);
        end
    endtask

    task automatic wait_ridx(input string name, input int target, input int limit);
        int k;
        k = 0;
        while (ridx < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (ridx < target) begin
            errors++;
            $display("FAIL %s: rises=%0d expected %0d", name, ridx, target);
        end
    endtask

    task automatic do_reset(input logic rdy, input logic [15:0] ma, input logic [15:0] mb);
        @(negedge clk);
        gen_on = 1'b0;
        reset  = 1'b1;
        enable = 1'b1;
        ready  = rdy;
        mask_a = ma;
        mask_b = mb;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        gen_on = 1'b1;
    endtask

    initial begin
        int t1;
        int base;

        vecs[0] = '{16'hFFFF, 16, 1'b1};
        vecs[1] = '{16'h0000,  0, 1'b0};
        vecs[2] = '{16'h5555,  8, 1'b0};
        vecs[3] = '{16'hAAAA,  8, 1'b1};
        vecs[4] = '{16'h8001,  2, 1'b1};
        vecs[5] = '{16'h0F0F,  8, 1'b0};

        reset  = 1'b1;
        enable = 1'b0;
        ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count",    32'(count),    0);
        chk("rst_valid",    32'(valid),    0);
        chk("rst_overrun",  32'(overrun),  0);
        chk("rst_decision", 32'(decision), 0);
        chk("rst_busy",     32'(busy),     0);

        // Table: two full windows per pattern, ready held high.
        for (int i = 0; i < 6; i++) begin
            do_reset(1'b1, vecs[i].mask, vecs[i].mask);
            wait_valid($sformatf("v%0d_win1", i), 300);
            t1 = cyc;
            chk($sformatf("v%0d_count1", i),  32'(count),    32'(vecs[i].exp_count));
            chk($sformatf("v%0d_dec", i),     32'(decision), 32'(vecs[i].exp_dec));
            chk($sformatf("v%0d_overrun", i), 32'(overrun),  0);
            chk($sformatf("v%0d_busy", i),    32'(busy),     1);
            @(negedge clk);
            chk($sformatf("v%0d_valid_drop", i), 32'(valid), 0);
            wait_valid($sformatf("v%0d_win2", i), 200);
            chk($sformatf("v%0d_period", i), 32'(cyc - t1),  128);
            chk($sformatf("v%0d_count2", i), 32'(count),     32'(vecs[i].exp_count));
        end

        // Overrun: ready low across a window of 0s then a window of 1s.
        do_reset(1'b0, 16'h0000, 16'hFFFF);
        wait_valid("ovr_win1", 300);
        chk("ovr_count1", 32'(count),   0);
        chk("ovr_flag1",  32'(overrun), 0);
        begin
            int k;
            k = 0;
            while (overrun !== 1'b1 && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        chk("ovr_flag2",  32'(overrun), 1);
        chk("ovr_count2", 32'(count),   0);
        chk("ovr_valid2", 32'(valid),   1);
        ready = 1'b1;
        @(negedge clk);
        chk("ovr_valid_drop", 32'(valid),   0);
        chk("ovr_sticky",     32'(overrun), 1);

        // ready pulsed exactly on the publish edge of window 2.
        do_reset(1'b0, 16'h0000, 16'hFFFF);
        wait_valid("pulse_win1", 300);
        chk("pulse_count1", 32'(count), 0);
        repeat (127) @(posedge clk);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("pulse_count2",  32'(count),   16);
        chk("pulse_valid2",  32'(valid),   1);
        chk("pulse_overrun", 32'(overrun), 0);

        // Enable dropped in the same cycle the 6th rise is seen; phase 6 is a 0.
        do_reset(1'b1, 16'hFFDF, 16'hFFFF);
        wait_ridx("en_rise6", 6, 200);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("en_busy_off", 32'(busy),     0);
        chk("en_no_pub",   32'(valid),    0);
        chk("en_decision", 32'(decision), 1);
        begin
            int k;
            k = 0;
            while (cmp_p1 !== 1'b1 && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        @(negedge clk);
        enable = 1'b1;   // re-enabled while cmp_p1 is already high
        base = ridx;
        wait_valid("en_win", 400);
        chk("en_rises",  32'(ridx - base), 16);
        chk("en_count",  32'(count),       16);

        // Reset after 10 samples of window 2 with a result pending.
        do_reset(1'b0, 16'hFFFF, 16'hFFFF);
        wait_valid("rs_win1", 300);
        chk("rs_count1", 32'(count), 16);
        base = ridx;
        wait_ridx("rs_rise10", base + 10, 200);
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rs_count",    32'(count),    0);
        chk("rs_valid",    32'(valid),    0);
        chk("rs_overrun",  32'(overrun),  0);
        chk("rs_decision", 32'(decision), 0);
        chk("rs_busy",     32'(busy),     0);
        reset = 1'b0;
        base  = ridx;
        wait_valid("rs_win2", 300);
        chk("rs_rises",  32'(ridx - base), 16);
        chk("rs_count2", 32'(count),       16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
